lc3_reg_wb_arb: RTL and testbench

LC3_REG_WB_ARB -- requirements
Module: lc3_reg_wb_arb

---
 rtl/lc3_reg_wb_arb_pkg.sv | 27 ++
 rtl/lc3_nzp_gen.sv | 24 ++
 rtl/lc3_reg_wb_arb.sv | 145 ++++++++++++++
 tb/tb_lc3_reg_wb_arb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_reg_wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_reg_wb_arb_pkg
//  Description : Shared types and constants for the LC-3 register write-back
//                arbiter and its condition-code generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3_reg_wb_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } wb_state_t;

    // Request port indices
    localparam logic       c_port0     = 1'b0;
    localparam logic       c_port1     = 1'b1;

    // Condition codes {N,Z,P} after reset: Z set
    localparam logic [2:0] c_nzp_reset = 3'b010;

    // Number of general-purpose registers cleared by the init sequence
    localparam int         c_num_regs  = 8;

endpackage : lc3_reg_wb_arb_pkg
`default_nettype wire

// File: rtl/lc3_nzp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_nzp_gen
//  Description : Combinational condition-code generator. Maps a 16-bit value
//                to one-hot {N,Z,P}.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_nzp_gen (
    input  logic [15:0] i_value,
    output logic [2:0]  o_nzp
);

    // Sign bit wins, then zero test, otherwise positive
    always_comb begin
        o_nzp = 3'b001;
        if (i_value[15]) begin
            o_nzp = 3'b100;
        end else if (i_value == 16'h0000) begin
            o_nzp = 3'b010;
        end
    end

endmodule : lc3_nzp_gen
`default_nettype wire

// File: rtl/lc3_reg_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_reg_wb_arb
//  Description : Two-port round-robin write-back arbiter for the LC-3 register
//                file, with a post-reset register clear sequence and
//                condition-code update on granted writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_reg_wb_arb
    import lc3_reg_wb_arb_pkg::*;
#(
    parameter logic [15:0] INIT_VAL = 16'h0000,
    parameter bit          INIT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [2:0]  req0_dr,
    input  logic [15:0] req0_data,
    input  logic        req0_setcc,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [2:0]  req1_dr,
    input  logic [15:0] req1_data,
    input  logic        req1_setcc,
    output logic        req1_ready,

    output logic        LD_REG,
    output logic [2:0]  DR,
    output logic [15:0] REGin,
    output logic [2:0]  NZP,
    output logic        init_busy
);

    localparam logic [2:0] c_last_idx = 3'(c_num_regs - 1);

    wb_state_t   r_state;
    logic [2:0]  r_cnt;
    logic        r_last;      // port granted most recently
    logic        r_ld_reg;
    logic [2:0]  r_dr;
    logic [15:0] r_regin;
    logic [2:0]  r_nzp;

    wb_state_t   w_state_nxt;
    logic [2:0]  w_cnt_nxt;
    logic        w_last_nxt;
    logic        w_ld_reg_nxt;
    logic [2:0]  w_dr_nxt;
    logic [15:0] w_regin_nxt;
    logic [2:0]  w_nzp_nxt;
    logic        w_grant0;
    logic        w_grant1;
    logic [15:0] w_sel_data;
    logic [2:0]  w_sel_nzp;

    // Condition codes for whichever port's data is being considered
    assign w_sel_data = w_grant1 ? req1_data : req0_data;

    lc3_nzp_gen u_nzp_gen (
        .i_value (w_sel_data),
        .o_nzp   (w_sel_nzp)
    );

    // State and output registers; reset forces clear-sequence start immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= INIT_EN ? ST_INIT : ST_RUN;
            r_cnt    <= 3'd0;
            r_last   <= c_port1;
            r_ld_reg <= 1'b0;
            r_dr     <= 3'd0;
            r_regin  <= 16'h0000;
            r_nzp    <= c_nzp_reset;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last   <= w_last_nxt;
            r_ld_reg <= w_ld_reg_nxt;
            r_dr     <= w_dr_nxt;
            r_regin  <= w_regin_nxt;
            r_nzp    <= w_nzp_nxt;
        end
    end

    // Next-state, grant and write-back selection
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_last_nxt   = r_last;
        w_ld_reg_nxt = 1'b0;
        w_dr_nxt     = r_dr;
        w_regin_nxt  = r_regin;
        w_nzp_nxt    = r_nzp;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;

        case (r_state)
            ST_INIT: begin
                // Clear one register per cycle; requests simply wait
                w_ld_reg_nxt = 1'b1;
                w_dr_nxt     = r_cnt;
                w_regin_nxt  = INIT_VAL;
                w_cnt_nxt    = r_cnt + 3'd1;
                if (r_cnt == c_last_idx) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                // Round-robin: on a tie the port not granted last wins
                w_grant0 = req0_valid && (!req1_valid || (r_last == c_port1));
                w_grant1 = req1_valid && (!req0_valid || (r_last == c_port0));
                if (w_grant0) begin
                    w_ld_reg_nxt = 1'b1;
                    w_dr_nxt     = req0_dr;
                    w_regin_nxt  = req0_data;
                    w_last_nxt   = c_port0;
                    if (req0_setcc) begin
                        w_nzp_nxt = w_sel_nzp;
                    end
                end else if (w_grant1) begin
                    w_ld_reg_nxt = 1'b1;
                    w_dr_nxt     = req1_dr;
                    w_regin_nxt  = req1_data;
                    w_last_nxt   = c_port1;
                    if (req1_setcc) begin
                        w_nzp_nxt = w_sel_nzp;
                    end
                end
            end
        endcase
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign LD_REG     = r_ld_reg;
    assign DR         = r_dr;
    assign REGin      = r_regin;
    assign NZP        = r_nzp;
    assign init_busy  = (r_state == ST_INIT);

endmodule : lc3_reg_wb_arb
`default_nettype wire

// File: tb/tb_lc3_reg_wb_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_reg_wb_arb
//  Description : Self-checking bench for lc3_reg_wb_arb. Directed scenarios
//                plus randomized traffic and asynchronous resets, compared
//                against a behavioural model of the write-back rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_reg_wb_arb;

    localparam logic [15:0] P_INIT = 16'h1234;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0]  req0_dr = '0, req1_dr = '0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic        req0_setcc = 1'b0, req1_setcc = 1'b0;
    logic        req0_ready, req1_ready;
    logic        LD_REG;
    logic [2:0]  DR;
    logic [15:0] REGin;
    logic [2:0]  NZP;
    logic        init_busy;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int          m_init_left;
    int          m_last;
    logic        m_ld;
    logic [2:0]  m_dr;
    logic [15:0] m_regin;
    logic [2:0]  m_nzp;

    lc3_reg_wb_arb #(.INIT_VAL(P_INIT), .INIT_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_dr    (req0_dr),
        .req0_data  (req0_data),
        .req0_setcc (req0_setcc),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_dr    (req1_dr),
        .req1_data  (req1_data),
        .req1_setcc (req1_setcc),
        .req1_ready (req1_ready),
        .LD_REG     (LD_REG),
        .DR         (DR),
        .REGin      (REGin),
        .NZP        (NZP),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'h0000)  return 3'b010;
        return 3'b001;
    endfunction

    function automatic void model_reset();
        m_init_left = 8;
        m_last      = 1;
        m_ld        = 1'b0;
        m_dr        = 3'd0;
        m_regin     = 16'h0000;
        m_nzp       = 3'b010;
    endfunction

    task automatic check_outputs();
        check("LD_REG",    32'(LD_REG),    32'(m_ld));
        check("DR",        32'(DR),        32'(m_dr));
        check("REGin",     32'(REGin),     32'(m_regin));
        check("NZP",       32'(NZP),       32'(m_nzp));
        check("init_busy", 32'(init_busy), 32'(m_init_left > 0));
    endtask

    // Called at a falling edge: apply one cycle of requests, check grants,
    // advance the model across the rising edge, check registered outputs.
    task automatic step(input logic v0, input logic [2:0] d0, input logic [15:0] x0, input logic s0,
                        input logic v1, input logic [2:0] d1, input logic [15:0] x1, input logic s1);
        int g;
        req0_valid = v0; req0_dr = d0; req0_data = x0; req0_setcc = s0;
        req1_valid = v1; req1_dr = d1; req1_data = x1; req1_setcc = s1;
        #1;
        g = -1;
        if (m_init_left == 0) begin
            if (v0 && v1)  g = 1 - m_last;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        check("req0_ready", 32'(req0_ready), 32'(g == 0));
        check("req1_ready", 32'(req1_ready), 32'(g == 1));
        if (m_init_left > 0) begin
            m_ld    = 1'b1;
            m_dr    = 3'(8 - m_init_left);
            m_regin = P_INIT;
            m_init_left--;
        end else if (g == 0) begin
            m_ld = 1'b1; m_dr = d0; m_regin = x0; m_last = 0;
            if (s0) m_nzp = nzp_of(x0);
        end else if (g == 1) begin
            m_ld = 1'b1; m_dr = d1; m_regin = x1; m_last = 1;
            if (s1) m_nzp = nzp_of(x1);
        end else begin
            m_ld = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse in the middle of a low clock phase
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
    endtask

    function automatic logic [15:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'h8000 | 16'($urandom);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs();

        // Clear sequence with no traffic, then idle RUN
        idle(10);

        // Single port-0 request with condition codes
        step(1, 3'd3, 16'h8001, 1, 0, 0, 0, 0);
        idle(1);

        // Zero via port 1 sets Z; port 0 without setcc leaves it
        step(0, 0, 0, 0, 1, 3'd2, 16'h0000, 1);
        step(1, 3'd4, 16'h0005, 0, 0, 0, 0, 0);
        idle(1);

        // Both ports contending after a fresh reset: alternating grants
        pulse_reset();
        idle(8);
        for (int i = 0; i < 4; i++) step(1, 3'd5, 16'h0011, 1, 1, 3'd5, 16'hF000, 1);
        idle(1);

        // Reset mid-clear at count 4, then requests held through the clear
        pulse_reset();
        idle(4);
        pulse_reset();
        for (int i = 0; i < 10; i++) step(1, 3'd1, 16'h7FFF, 1, 1, 3'd6, 16'h0000, 1);
        idle(1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) pulse_reset();
            step($urandom_range(0, 9) < 6, 3'($urandom), rand_data(), 1'($urandom),
                 $urandom_range(0, 9) < 6, 3'($urandom), rand_data(), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_lc3_reg_wb_arb
`default_nettype wire
